// File: rtl/sprite_pixel_gen.sv
`timescale 1ns/1ps
// sprite_pixel_gen: 256x256 sprite window pixel source, pattern rows fetched during hblank.
// Define SPRITE_COLLISION_EN to build the sticky sprite-overlap detector on o_Collision.
module sprite_pixel_gen #(
    parameter int NUM_SPRITES = 4
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic [9:0]  i_Row,
    input  logic [9:0]  i_Column,
    input  logic        i_Attr_We,
    input  logic [2:0]  i_Attr_Addr,
    input  logic [16:0] i_Attr_Data,
    output logic [6:0]  o_Rom_Addr,
    input  logic [31:0] i_Rom_Data,
    output logic [9:0]  o_Row,
    output logic [9:0]  o_Column,
    output logic [1:0]  o_Pixel,
    output logic        o_Collision
);

    localparam int IDX_MAX = NUM_SPRITES - 1;

    typedef enum logic [1:0] {IDLE, SCAN, WAIT, LOAD} state_t;

    // Pattern bits for pixel k: pixel 0 sits in [31:30], pixel 15 in [1:0].
    function automatic logic [1:0] pick_pixel(input logic [31:0] pat, input logic [3:0] k);
        logic [4:0] hi;
        hi = 5'd31 - {k, 1'b0};
        return pat[hi -: 2];
    endfunction

    // Lowest sprite index with a nonzero pixel wins.
    function automatic logic [1:0] prio_pixel(input logic [1:0] c [NUM_SPRITES]);
        logic [1:0] p;
        p = 2'b00;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (c[i] != 2'b00) p = c[i];
        end
        return p;
    endfunction

    logic       attr_en [NUM_SPRITES];
    logic [7:0] attr_y  [NUM_SPRITES];
    logic [7:0] attr_x  [NUM_SPRITES];

    logic [NUM_SPRITES-1:0] slot_vld;
    logic [31:0]            slot_pat [NUM_SPRITES];
    logic [7:0]             slot_x   [NUM_SPRITES];

    state_t     state, state_nxt;
    logic [2:0] idx, idx_nxt;
    logic [7:0] line, line_nxt;
    logic [6:0] rom_addr_nxt;
    logic       load, clear_slots;

    logic       cur_en;
    logic [7:0] cur_y, cur_x;
    logic [8:0] d;
    logic [9:0] next_line;
    logic       hit, last;

    logic       win;
    logic [7:0] wx;
    logic [8:0] dx;
    logic [1:0] contrib_c  [NUM_SPRITES];
    logic [1:0] contrib_p1 [NUM_SPRITES];
    logic [9:0] row_p1, col_p1;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                attr_en[i] <= 1'b0;
                attr_y[i]  <= 8'd0;
                attr_x[i]  <= 8'd0;
            end
        end else if (i_Attr_We) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (i_Attr_Addr == 3'(i)) begin
                    attr_en[i] <= i_Attr_Data[16];
                    attr_y[i]  <= i_Attr_Data[15:8];
                    attr_x[i]  <= i_Attr_Data[7:0];
                end
            end
        end
    end

    always_comb begin
        cur_en = 1'b0;
        cur_y  = 8'd0;
        cur_x  = 8'd0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (idx == 3'(i)) begin
                cur_en = attr_en[i];
                cur_y  = attr_y[i];
                cur_x  = attr_x[i];
            end
        end
        next_line = (i_Row == 10'd524) ? 10'd0 : i_Row + 10'd1;
        // Negative distances set bit 8, so one zero test covers 0..15.
        d    = {1'b0, line} - {1'b0, cur_y};
        hit  = cur_en && (d[8:4] == 5'd0);
        last = (idx == 3'(IDX_MAX));
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        line_nxt     = line;
        rom_addr_nxt = o_Rom_Addr;
        load         = 1'b0;
        clear_slots  = 1'b0;
        case (state)
            IDLE: begin
                if (i_Column == 10'd640) begin
                    clear_slots = 1'b1;
                    if (next_line < 10'd256) begin
                        state_nxt = SCAN;
                        idx_nxt   = 3'd0;
                        line_nxt  = next_line[7:0];
                    end
                end
            end
            SCAN: begin
                if (hit) begin
                    rom_addr_nxt = {idx, d[3:0]};
                    state_nxt    = WAIT;
                end else if (last) begin
                    state_nxt = IDLE;
                end else begin
                    idx_nxt = idx + 3'd1;
                end
            end
            WAIT: state_nxt = LOAD;
            LOAD: begin
                load = 1'b1;
                if (last) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SCAN;
                    idx_nxt   = idx + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state      <= IDLE;
            idx        <= 3'd0;
            line       <= 8'd0;
            o_Rom_Addr <= 7'd0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            line       <= line_nxt;
            o_Rom_Addr <= rom_addr_nxt;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            slot_vld <= '0;
        end else if (clear_slots) begin
            slot_vld <= '0;
        end else if (load) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (idx == 3'(i)) slot_vld[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (load && idx == 3'(i)) begin
                slot_pat[i] <= i_Rom_Data;
                slot_x[i]   <= cur_x;
            end
        end
    end

    always_comb begin
        win = (i_Row < 10'd256) && (i_Column >= 10'd16) && (i_Column < 10'd272);
        wx  = 8'(i_Column - 10'd16);
        dx  = 9'd0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            contrib_c[i] = 2'b00;
            // 9-bit distance: sprites near the right edge clip instead of wrapping.
            dx = {1'b0, wx} - {1'b0, slot_x[i]};
            if (win && slot_vld[i] && dx[8:4] == 5'd0) begin
                contrib_c[i] = pick_pixel(slot_pat[i], dx[3:0]);
            end
        end
    end

    // Stage 1: per-slot contributions and delayed scan position.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            for (int i = 0; i < NUM_SPRITES; i++) contrib_p1[i] <= 2'b00;
            row_p1 <= 10'd0;
            col_p1 <= 10'd0;
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) contrib_p1[i] <= contrib_c[i];
            row_p1 <= i_Row;
            col_p1 <= i_Column;
        end
    end

    // Stage 2: priority resolve.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            o_Pixel  <= 2'b00;
            o_Row    <= 10'd0;
            o_Column <= 10'd0;
        end else begin
            o_Pixel  <= prio_pixel(contrib_p1);
            o_Row    <= row_p1;
            o_Column <= col_p1;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic seen, multi;

    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (contrib_p1[i] != 2'b00) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
            end
        end
    end

    // Sticky per frame; cleared as the first pixel of the frame is presented.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            o_Collision <= 1'b0;
        end else if (row_p1 == 10'd0 && col_p1 == 10'd0) begin
            o_Collision <= 1'b0;
        end else if (multi) begin
            o_Collision <= 1'b1;
        end
    end
`else
    assign o_Collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_pixel_gen.sv
`timescale 1ns/1ps
// Directed bench for sprite_pixel_gen: drives scan positions directly, models the pattern ROM.
module tb_sprite_pixel_gen;

    logic        i_Clk = 1'b0;
    logic        i_Rst_L;
    logic [9:0]  i_Row, i_Column;
    logic        i_Attr_We;
    logic [2:0]  i_Attr_Addr;
    logic [16:0] i_Attr_Data;
    logic [6:0]  o_Rom_Addr;
    logic [31:0] i_Rom_Data;
    logic [9:0]  o_Row, o_Column;
    logic [1:0]  o_Pixel;
    logic        o_Collision;

    always #5 i_Clk = ~i_Clk;

    sprite_pixel_gen #(.NUM_SPRITES(4)) dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Row(i_Row), .i_Column(i_Column),
        .i_Attr_We(i_Attr_We), .i_Attr_Addr(i_Attr_Addr), .i_Attr_Data(i_Attr_Data),
        .o_Rom_Addr(o_Rom_Addr), .i_Rom_Data(i_Rom_Data), .o_Row(o_Row),
        .o_Column(o_Column), .o_Pixel(o_Pixel), .o_Collision(o_Collision)
    );

    logic [31:0] rom [128];
    logic [31:0] rom_q;
    always @(posedge i_Clk) rom_q <= rom[o_Rom_Addr];
    assign i_Rom_Data = rom_q;

`ifdef SPRITE_COLLISION_EN
    localparam int COLL = 1;
`else
    localparam int COLL = 0;
`endif

    int         pix_log  [256][512];
    int         coll_log [256][512];
    logic [6:0] addr_log [64];
    logic [9:0] acol;
    logic       nz_en = 1'b0;
    int         nz_count = 0;
    assign acol = i_Column - 10'd636;

    always @(negedge i_Clk) begin
        if (o_Row < 10'd256 && o_Column < 10'd300) begin
            pix_log[o_Row[7:0]][o_Column[8:0]]  <= int'(o_Pixel);
            coll_log[o_Row[7:0]][o_Column[8:0]] <= int'(o_Collision);
        end
        if (i_Column >= 10'd636 && i_Column <= 10'd672) addr_log[acol[5:0]] <= o_Rom_Addr;
        if (!nz_en) nz_count <= 0;
        else if (o_Pixel != 2'b00) nz_count <= nz_count + 1;
    end

    typedef struct {
        string name;
        int    row;
        int    col;
        int    coll;
        int    exp;
    } vec_t;
    vec_t vecs[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input string tag, input int r, input int c, input int cl, input int e);
        vec_t v;
        v.name = $sformatf("%s_r%0d_c%0d", tag, r, c);
        v.row = r; v.col = c; v.coll = cl; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            int act;
            act = (vecs[i].coll != 0) ? coll_log[vecs[i].row][vecs[i].col]
                                      : pix_log[vecs[i].row][vecs[i].col];
            chk(vecs[i].name, act, vecs[i].exp);
        end
        vecs.delete();
    endtask

    function automatic int count_nz(input int r, input int lo, input int hi);
        int n;
        n = 0;
        for (int c = lo; c <= hi; c++) if (pix_log[r][c] != 0) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic run_line(input int r, input int lo, input int hi, input int wcol,
                            input logic [2:0] wa, input logic [16:0] wd);
        for (int c = lo; c <= hi; c++) begin
            i_Row       = 10'(r);
            i_Column    = 10'(c);
            i_Attr_We   = (c == wcol);
            i_Attr_Addr = wa;
            i_Attr_Data = wd;
            tick();
        end
        i_Attr_We = 1'b0;
    endtask

    task automatic do_row(input int r);
        run_line(r, 0, 290, -1, 3'd0, 17'd0);
        run_line(r, 636, 672, -1, 3'd0, 17'd0);
    endtask

    task automatic set_attr(input int a, input logic en, input logic [7:0] y, input logic [7:0] x);
        run_line(300, 0, 0, 0, 3'(a), {en, y, x});
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 128; a++) rom[a] = 32'h0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_Rst_L = 1'b0; i_Row = 10'd5; i_Column = 10'd7;
        i_Attr_We = 1'b0; i_Attr_Addr = 3'd0; i_Attr_Data = 17'd0;
        clear_rom();
        repeat (5) tick();
        chk("init_pixel", int'(o_Pixel), 0);
        chk("init_row", int'(o_Row), 0);
        chk("init_col", int'(o_Column), 0);
        chk("init_rom_addr", int'(o_Rom_Addr), 0);
        chk("init_coll", int'(o_Collision), 0);
        i_Rst_L = 1'b1;

        // Single sprite at Y=20, X=10, pattern 0,1,2,3 repeating.
        rom[0] = 32'h1B1B_1B1B;
        set_attr(0, 1'b1, 8'd20, 8'd10);
        do_row(18); do_row(19); do_row(20);
        chk("single_row19_blank", count_nz(19, 0, 290), 0);
        add("single", 20, 25, 0, 0);
        for (int c = 26; c <= 41; c++) add("single", 20, c, 0, (c - 26) % 4);
        add("single", 20, 42, 0, 0);
        run_vecs();

        // Priority: two sprites at origin, row 0 fetched during row 524.
        clear_rom();
        rom[0]  = 32'h5555_0000;
        rom[16] = 32'hFFFF_FFFF;
        set_attr(1, 1'b1, 8'd0, 8'd0);
        set_attr(0, 1'b1, 8'd0, 8'd0);
        set_attr(2, 1'b0, 8'd0, 8'd0);
        set_attr(3, 1'b0, 8'd0, 8'd0);
        run_line(524, 636, 672, -1, 3'd0, 17'd0);
        chk("prio_addr_s0", int'(addr_log[6]), 0);
        chk("prio_addr_s1", int'(addr_log[9]), 16);
        do_row(0);
        add("prio", 0, 15, 0, 0);
        for (int c = 16; c <= 23; c++) add("prio", 0, c, 0, 1);
        for (int c = 24; c <= 31; c++) add("prio", 0, c, 0, 3);
        add("prio", 0, 32, 0, 0);
        run_vecs();

        // Clipping at the right and bottom window edges.
        clear_rom();
        for (int k = 0; k < 16; k++) rom[k] = 32'hFFFF_FFFF;
        set_attr(1, 1'b0, 8'd0, 8'd0);
        set_attr(0, 1'b1, 8'd250, 8'd248);
        for (int r = 248; r <= 255; r++) do_row(r);
        run_line(524, 636, 672, -1, 3'd0, 17'd0);
        do_row(0);
        add("clip", 249, 264, 0, 0);
        add("clip", 250, 263, 0, 0);
        add("clip", 250, 264, 0, 3);
        add("clip", 250, 271, 0, 3);
        add("clip", 250, 272, 0, 0);
        add("clip", 255, 263, 0, 0);
        add("clip", 255, 264, 0, 3);
        add("clip", 255, 271, 0, 3);
        add("clip", 0, 264, 0, 0);
        run_vecs();
        chk("clip_row0_blank", count_nz(0, 0, 290), 0);

        // Attribute write mid-line: new X shows one row later.
        clear_rom();
        for (int k = 0; k < 16; k++) begin
            rom[k]      = 32'hFFFF_FFFF;
            rom[32 + k] = 32'h4000_0000;
        end
        set_attr(0, 1'b1, 8'd25, 8'd50);
        set_attr(2, 1'b1, 8'd28, 8'd200);
        do_row(29);
        run_line(30, 0, 290, 100, 3'd0, {1'b1, 8'd25, 8'd100});
        run_line(30, 636, 672, -1, 3'd0, 17'd0);
        chk("attr_addr_c641", int'(addr_log[5]), 34);
        chk("attr_addr_c642", int'(addr_log[6]), 6);
        chk("attr_addr_c645", int'(addr_log[9]), 6);
        chk("attr_addr_c646", int'(addr_log[10]), 35);
        chk("attr_addr_c660", int'(addr_log[24]), 35);
        do_row(31);
        add("attr", 30, 65, 0, 0);
        add("attr", 30, 66, 0, 3);
        add("attr", 30, 81, 0, 3);
        add("attr", 30, 116, 0, 0);
        add("attr", 30, 216, 0, 1);
        add("attr", 30, 217, 0, 0);
        add("attr", 31, 66, 0, 0);
        add("attr", 31, 115, 0, 0);
        add("attr", 31, 116, 0, 3);
        add("attr", 31, 131, 0, 3);
        add("attr", 31, 132, 0, 0);
        add("attr", 31, 216, 0, 1);
        run_vecs();

        // Overlapping sprites: priority and sticky collision flag.
        clear_rom();
        for (int k = 0; k < 16; k++) begin
            rom[k]      = 32'hFFFF_FFFF;
            rom[16 + k] = 32'h5555_5555;
        end
        set_attr(2, 1'b0, 8'd0, 8'd0);
        set_attr(0, 1'b1, 8'd40, 8'd60);
        set_attr(1, 1'b1, 8'd40, 8'd68);
        do_row(39); do_row(40);
        add("ovl", 40, 76, 0, 3);
        add("ovl", 40, 84, 0, 3);
        add("ovl", 40, 91, 0, 3);
        add("ovl", 40, 92, 0, 1);
        add("ovl", 40, 99, 0, 1);
        add("ovl", 40, 100, 0, 0);
        add("coll", 40, 83, 1, 0);
        add("coll", 40, 84, 1, COLL);
        add("coll", 40, 200, 1, COLL);
        run_vecs();
        run_line(524, 636, 672, -1, 3'd0, 17'd0);
        chk("coll_hold_r524", int'(o_Collision), COLL);
        do_row(0);
        add("coll", 0, 0, 1, 0);
        add("coll", 0, 100, 1, 0);
        run_vecs();

        // Reset in the middle of a displayed line.
        do_row(39);
        run_line(40, 0, 85, -1, 3'd0, 17'd0);
        i_Rst_L = 1'b0;
        run_line(40, 86, 90, -1, 3'd0, 17'd0);
        chk("rst_pixel", int'(o_Pixel), 0);
        chk("rst_row", int'(o_Row), 0);
        chk("rst_col", int'(o_Column), 0);
        chk("rst_rom_addr", int'(o_Rom_Addr), 0);
        chk("rst_coll", int'(o_Collision), 0);
        i_Rst_L = 1'b1;
        run_line(40, 91, 290, -1, 3'd0, 17'd0);
        chk("rst_slots_cleared", count_nz(40, 91, 290), 0);
        do_row(39); do_row(40);
        chk("rst_attrs_cleared", count_nz(40, 0, 290), 0);

        // A whole frame with only a disabled sprite.
        set_attr(0, 1'b0, 8'd100, 8'd100);
        nz_en = 1'b1;
        for (int r = 0; r <= 524; r++) begin
            run_line(r, 0, 20, -1, 3'd0, 17'd0);
            run_line(r, 110, 135, -1, 3'd0, 17'd0);
            run_line(r, 260, 275, -1, 3'd0, 17'd0);
            run_line(r, 638, 660, -1, 3'd0, 17'd0);
        end
        chk("frame_blank", nz_count, 0);
        nz_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
